// File: rtl/ball_collision_arbiter.sv
// Fixed-priority collision arbiter: grants at most one collision per frame.
// The spring and bumper sources carry per-frame cooldowns so a resting ball is not re-kicked.
module ball_collision_arbiter #(
  parameter int unsigned NUM_SRC         = 6,
  parameter int unsigned SPRING_IDX      = 2,
  parameter int unsigned BUMPER_IDX      = 4,
  parameter int unsigned SPRING_COOLDOWN = 5,
  parameter int unsigned BUMPER_COOLDOWN = 40,
  parameter int unsigned CNT_W           = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               pause,
  input  logic               reset_level,
  input  logic [NUM_SRC-1:0] col_req,
  input  logic [3:0]         hitEdgeCode,
  output logic               grant_valid,
  output logic [NUM_SRC-1:0] grant,
  output logic [3:0]         grant_edge,
  output logic               frame_locked,
  output logic [CNT_W-1:0]   drop_count
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state;
  logic [CNT_W-1:0]   springCd;
  logic [CNT_W-1:0]   bumperCd;
  logic [NUM_SRC-1:0] cooling;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] winner;
  logic               grantNow;

  always_comb begin
    cooling             = '0;
    cooling[SPRING_IDX] = (springCd != '0);
    cooling[BUMPER_IDX] = (bumperCd != '0);
    eligible            = col_req & ~cooling;
    // Isolate the lowest set bit: bit 0 has the highest priority.
    winner              = eligible & (~eligible + NUM_SRC'(1));
    grantNow            = (state == IDLE) && !pause && !startOfFrame && (eligible != '0);
  end

  assign frame_locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      springCd    <= '0;
      bumperCd    <= '0;
      grant_valid <= 1'b0;
      grant       <= '0;
      grant_edge  <= '0;
      drop_count  <= '0;
    end else if (reset_level) begin
      state       <= IDLE;
      springCd    <= '0;
      bumperCd    <= '0;
      grant_valid <= 1'b0;
      grant       <= '0;
      grant_edge  <= '0;
    end else if (pause) begin
      grant_valid <= 1'b0;
    end else begin
      grant_valid <= grantNow;
      if (startOfFrame) begin
        state      <= IDLE;
        grant      <= '0;
        grant_edge <= '0;
        if (springCd != '0) springCd <= springCd - CNT_W'(1);
        if (bumperCd != '0) bumperCd <= bumperCd - CNT_W'(1);
      end else if (grantNow) begin
        state      <= LOCKED;
        grant      <= winner;
        grant_edge <= hitEdgeCode;
        if (winner[SPRING_IDX]) springCd <= CNT_W'(SPRING_COOLDOWN);
        if (winner[BUMPER_IDX]) bumperCd <= CNT_W'(BUMPER_COOLDOWN);
      end
      if (!startOfFrame && (col_req != '0) && !grantNow && (drop_count != '1))
        drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ball_collision_arbiter.sv
// Directed bench for ball_collision_arbiter: priority, frame locking, cooldowns,
// pause, level restart and drop-counter saturation.
module tb_ball_collision_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic       pause;
  logic       reset_level;
  logic [5:0] col_req;
  logic [3:0] hitEdgeCode;
  logic       grant_valid;
  logic [5:0] grant;
  logic [3:0] grant_edge;
  logic       frame_locked;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;
  int expDrop = 0;

  ball_collision_arbiter #(
    .NUM_SRC(6), .SPRING_IDX(2), .BUMPER_IDX(4),
    .SPRING_COOLDOWN(5), .BUMPER_COOLDOWN(40), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .pause(pause),
    .reset_level(reset_level), .col_req(col_req), .hitEdgeCode(hitEdgeCode),
    .grant_valid(grant_valid), .grant(grant), .grant_edge(grant_edge),
    .frame_locked(frame_locked), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; pause = 1'b0; reset_level = 1'b0;
    col_req = '0; hitEdgeCode = '0;
    tick(); tick();
    chk("rst_valid", grant_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_edge", grant_edge, 0);
    chk("rst_locked", frame_locked, 0);
    chk("rst_drop", drop_count, 0);

    // 1: obstacle beats bumper
    reset = 1'b0; col_req = 6'b010010; hitEdgeCode = 4'b1010;
    tick();
    chk("t1_valid", grant_valid, 1);
    chk("t1_grant", grant, 6'b000010);
    chk("t1_edge", grant_edge, 4'b1010);
    chk("t1_locked", frame_locked, 1);
    chk("t1_drop", drop_count, 0);

    // 2: requests while locked are dropped
    col_req = 6'b000001; hitEdgeCode = 4'b0001;
    tick();
    chk("t2_pulse", grant_valid, 0);
    tick(); tick();
    expDrop = 3;
    chk("t2_drop", drop_count, expDrop);
    chk("t2_hold", grant, 6'b000010);
    frame();
    chk("t2_sof_valid", grant_valid, 0);
    chk("t2_sof_grant", grant, 0);
    chk("t2_sof_locked", frame_locked, 0);
    chk("t2_sof_drop", drop_count, expDrop);
    tick();
    chk("t2_regrant", grant, 6'b000001);
    chk("t2_regrant_v", grant_valid, 1);
    col_req = '0;
    tick();
    chk("t2_one_pulse", grant_valid, 0);

    // 3: bumper cooldown of 40 frames; flipper unaffected
    frame();
    col_req = 6'b010000; hitEdgeCode = 4'b0100;
    tick();
    chk("t3_bump", grant, 6'b010000);
    col_req = '0;
    for (int k = 1; k <= 40; k++) begin
      frame();
      if (k == 1 || k == 20 || k == 39) begin
        col_req = 6'b010000;
        tick();
        expDrop++;
        chk($sformatf("t3_block_%0d", k), grant_valid, 0);
        col_req = '0;
      end else if (k == 10) begin
        col_req = 6'b011000;
        tick();
        chk("t3_flipper", grant, 6'b001000);
        col_req = '0;
      end else if (k == 40) begin
        col_req = 6'b010000;
        tick();
        chk("t3_bump_again", grant, 6'b010000);
        chk("t3_bump_again_v", grant_valid, 1);
        col_req = '0;
      end
    end
    chk("t3_drop", drop_count, expDrop);

    // 4: startOfFrame beats a same-cycle request
    startOfFrame = 1'b1; col_req = 6'b000100; hitEdgeCode = 4'b0010;
    tick();
    startOfFrame = 1'b0;
    chk("t4_sof_valid", grant_valid, 0);
    chk("t4_sof_grant", grant, 0);
    chk("t4_sof_drop", drop_count, expDrop);
    tick();
    chk("t4_spring", grant, 6'b000100);
    chk("t4_spring_edge", grant_edge, 4'b0010);
    col_req = '0;
    frame(); frame();

    // 5: pause freezes cooldown, grants and drops (spring cooldown now 3)
    pause = 1'b1; col_req = 6'b000010;
    for (int k = 0; k < 4; k++) begin
      frame();
      tick();
      chk("t5_pause_valid", grant_valid, 0);
    end
    chk("t5_pause_grant", grant, 0);
    chk("t5_pause_drop", drop_count, expDrop);
    pause = 1'b0; col_req = '0;
    frame(); frame();
    col_req = 6'b000100;
    tick();
    expDrop++;
    chk("t5_still_cool", grant_valid, 0);
    chk("t5_drop", drop_count, expDrop);
    col_req = '0;
    frame();
    col_req = 6'b000100;
    tick();
    chk("t5_spring_free", grant, 6'b000100);
    chk("t5_spring_free_v", grant_valid, 1);

    // 6: saturation, level restart, full reset
    col_req = 6'b000001;
    repeat (300) tick();
    chk("t6_sat", drop_count, 8'hFF);
    tick();
    chk("t6_sat_hold", drop_count, 8'hFF);
    reset_level = 1'b1; pause = 1'b1; col_req = '0;
    tick();
    reset_level = 1'b0; pause = 1'b0;
    chk("t6_lvl_grant", grant, 0);
    chk("t6_lvl_edge", grant_edge, 0);
    chk("t6_lvl_locked", frame_locked, 0);
    chk("t6_lvl_drop", drop_count, 8'hFF);
    col_req = 6'b000100; hitEdgeCode = 4'b1000;
    tick();
    chk("t6_lvl_spring", grant, 6'b000100);
    col_req = '0;
    frame();
    col_req = 6'b010000;
    tick();
    chk("t6_lvl_bumper", grant, 6'b010000);
    col_req = '0;
    reset = 1'b1;
    tick();
    chk("t6_rst_drop", drop_count, 0);
    chk("t6_rst_grant", grant, 0);
    reset = 1'b0; col_req = 6'b000100;
    tick();
    chk("t6_rst_spring", grant, 6'b000100);
    chk("t6_rst_spring_v", grant_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
